// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state codes and default width for the bit-serial adder controller
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result handshake bundle between a datapath and the serial adder
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             done_valid;
    logic             done_ready;

    modport master (
        output start_valid, a_in, b_in, done_ready,
        input  start_ready, sum_out, carry_out, done_valid
    );

    modport slave (
        input  start_valid, a_in, b_in, done_ready,
        output start_ready, sum_out, carry_out, done_valid
    );

endinterface

// File: rtl/serial_add_ctrl_ha_cell.sv
// rtl/serial_add_ctrl_ha_cell.sv - gate-level half adder, two of which form the serial full adder
module ha_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    xor u_xor (sum, a, b);
    and u_and (carry, a, b);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller: one full-adder cell stepped LSB first over WIDTH cycles
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic ha1_sum, ha1_carry, fa_sum, ha2_carry, fa_carry;
    logic accept, last_bit, release_done;

    ha_cell u_ha1 (.a(a_q[0]),  .b(b_q[0]), .sum(ha1_sum), .carry(ha1_carry));
    ha_cell u_ha2 (.a(ha1_sum), .b(c_q),    .sum(fa_sum),  .carry(ha2_carry));

    assign fa_carry     = ha1_carry | ha2_carry;
    assign accept       = bus.start_valid & bus.start_ready;
    assign last_bit     = (cnt_q == CNT_W'(WIDTH - 1));
    assign release_done = bus.done_valid & bus.done_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = accept       ? ST_RUN  : ST_IDLE;
            ST_RUN:  state_d = last_bit     ? ST_DONE : ST_RUN;
            ST_DONE: state_d = release_done ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registers hold outside of accept/RUN so the result survives DONE and IDLE.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        if (state_q == ST_IDLE && accept) begin
            a_d   = bus.a_in;
            b_d   = bus.b_in;
            sum_d = '0;
            c_d   = 1'b0;
            cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            sum_d = {fa_sum, sum_q[WIDTH-1:1]};
            c_d   = fa_carry;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        bus.start_ready = 1'b0;
        bus.done_valid  = 1'b0;
        busy            = 1'b0;
        case (state_q)
            ST_IDLE: bus.start_ready = ~rst;
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                bus.done_valid = 1'b1;
                busy           = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.sum_out   = sum_q;
    assign bus.carry_out = c_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and randomised checks of serial_add_ctrl at WIDTH=8 and WIDTH=13
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst8, rst13;
    logic busy8, busy13;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs8      = 0;
    int   hs13     = 0;
    logic done13   = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8))  bus8  ();
    serial_add_ctrl_if #(.WIDTH(13)) bus13 ();

    serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(bus8),  .busy(busy8));
    serial_add_ctrl #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst13), .bus(bus13), .busy(busy13));

    always @(posedge clk) begin
        if (bus8.done_valid && bus8.done_ready)   hs8  <= hs8 + 1;
        if (bus13.done_valid && bus13.done_ready) hs13 <= hs13 + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input int hold, output int lat, output int busy_n);
        logic [8:0] exp;
        exp = {1'b0, a} + {1'b0, b};
        @(negedge clk);
        check_eq({name, "_start_ready"}, 32'(bus8.start_ready), 32'd1);
        bus8.a_in = a; bus8.b_in = b; bus8.start_valid = 1'b1; bus8.done_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus8.start_valid = 1'b0; bus8.a_in = ~a; bus8.b_in = ~b;
        lat = 0; busy_n = 0;
        while (!bus8.done_valid && lat < 40) begin
            busy_n += int'(busy8);
            @(negedge clk);
            lat++;
        end
        busy_n += int'(busy8);
        check_eq({name, "_sum"}, 32'({bus8.carry_out, bus8.sum_out}), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            bus8.start_valid = 1'b1; bus8.a_in = 8'h11 + 8'(i); bus8.b_in = 8'h22;
            @(negedge clk);
            check_eq({name, "_hold_valid"}, 32'(bus8.done_valid), 32'd1);
            check_eq({name, "_hold_ready"}, 32'(bus8.start_ready), 32'd0);
            check_eq({name, "_hold_sum"}, 32'({bus8.carry_out, bus8.sum_out}), 32'(exp));
        end
        bus8.start_valid = 1'b0; bus8.done_ready = 1'b1;
        @(negedge clk);
        bus8.done_ready = 1'b0;
        check_eq({name, "_idle_valid"}, 32'(bus8.done_valid), 32'd0);
        check_eq({name, "_idle_busy"}, 32'(busy8), 32'd0);
        check_eq({name, "_idle_sum"}, 32'({bus8.carry_out, bus8.sum_out}), 32'(exp));
    endtask

    task automatic rand8(input int n);
        logic [7:0] a, b;
        logic [8:0] exp;
        int lat, base;
        base = hs8;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            if (i == 0) begin a = 8'hFF; b = 8'hFF; end
            exp = {1'b0, a} + {1'b0, b};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            check_eq("r8_start_ready", 32'(bus8.start_ready), 32'd1);
            bus8.a_in = a; bus8.b_in = b; bus8.start_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus8.start_valid = 1'b0; bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom);
            lat = 0;
            while (!bus8.done_valid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check_eq("r8_latency", 32'(lat), 32'd8);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_eq("r8_sum", 32'({bus8.carry_out, bus8.sum_out}), 32'(exp));
            bus8.done_ready = 1'b1;
            @(negedge clk);
            bus8.done_ready = 1'b0;
            check_eq("r8_released", 32'(bus8.done_valid), 32'd0);
        end
        check_eq("r8_result_count", 32'(hs8 - base), 32'(n));
    endtask

    task automatic rand13(input int n);
        logic [12:0] a, b;
        logic [13:0] exp;
        int lat;
        for (int i = 0; i < n; i++) begin
            a = 13'($urandom); b = 13'($urandom);
            if (i == 0) begin a = 13'h1FFF; b = 13'h0001; end
            exp = {1'b0, a} + {1'b0, b};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            check_eq("r13_start_ready", 32'(bus13.start_ready), 32'd1);
            bus13.a_in = a; bus13.b_in = b; bus13.start_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus13.start_valid = 1'b0; bus13.a_in = 13'($urandom); bus13.b_in = 13'($urandom);
            lat = 0;
            while (!bus13.done_valid && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            check_eq("r13_latency", 32'(lat), 32'd13);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_eq("r13_sum", 32'({bus13.carry_out, bus13.sum_out}), 32'(exp));
            bus13.done_ready = 1'b1;
            @(negedge clk);
            bus13.done_ready = 1'b0;
            check_eq("r13_released", 32'(bus13.done_valid), 32'd0);
        end
        check_eq("r13_result_count", 32'(hs13), 32'(n));
    endtask

    initial begin
        rst13 = 1'b1;
        bus13.start_valid = 1'b0; bus13.done_ready = 1'b0; bus13.a_in = '0; bus13.b_in = '0;
        repeat (3) @(negedge clk);
        rst13 = 1'b0;
        rand13(300);
        done13 = 1'b1;
    end

    initial begin
        int lat, busy_n, seen, guard;
        rst8 = 1'b1;
        bus8.start_valid = 1'b0; bus8.done_ready = 1'b0; bus8.a_in = '0; bus8.b_in = '0;
        #2;
        check_eq("rst_start_ready", 32'(bus8.start_ready), 32'd0);
        check_eq("rst_done_valid", 32'(bus8.done_valid), 32'd0);
        check_eq("rst_busy", 32'(busy8), 32'd0);
        check_eq("rst_sum", 32'({bus8.carry_out, bus8.sum_out}), 32'd0);
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        #1;
        check_eq("rel_start_ready", 32'(bus8.start_ready), 32'd1);
        check_eq("rel_busy", 32'(busy8), 32'd0);

        op8("wrap", 8'hFF, 8'h01, 0, lat, busy_n);
        check_eq("wrap_latency", 32'(lat), 32'd8);

        op8("basic", 8'h5A, 8'h25, 0, lat, busy_n);
        check_eq("basic_latency", 32'(lat), 32'd8);
        check_eq("basic_busy_cycles", 32'(busy_n), 32'd9);

        op8("bp", 8'h12, 8'h34, 5, lat, busy_n);
        check_eq("bp_latency", 32'(lat), 32'd8);

        // Abort after four RUN edges: bits 0..3 of C3+3C are in the sum register.
        @(negedge clk);
        bus8.a_in = 8'hC3; bus8.b_in = 8'h3C; bus8.start_valid = 1'b1;
        @(posedge clk);
        #1 bus8.start_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst8 = 1'b1;
        #1;
        check_eq("abort_done_valid", 32'(bus8.done_valid), 32'd0);
        check_eq("abort_busy", 32'(busy8), 32'd0);
        check_eq("abort_sum", 32'({bus8.carry_out, bus8.sum_out}), 32'd0);
        check_eq("abort_start_ready", 32'(bus8.start_ready), 32'd0);
        @(negedge clk);
        rst8 = 1'b0;
        #1;
        check_eq("abort_rel_ready", 32'(bus8.start_ready), 32'd1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done_valid || busy8) seen++;
        end
        check_eq("abort_no_result", 32'(seen), 32'd0);

        op8("after_abort", 8'h80, 8'h80, 0, lat, busy_n);
        check_eq("after_abort_latency", 32'(lat), 32'd8);

        rand8(500);

        guard = 0;
        while (!done13 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("w13_finished", 32'(done13), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
